rggen_axi4lite_wide_register_array: RTL and testbench
=====================================================

Name: rggen_axi4lite_wide_register_array

Overview:
Parametrised AXI4-Lite register array with ENTRIES identical registers, each DATA_WIDTH bits wide, spanning DATA_WIDTH/BUS_WIDTH bus words. Each bit is fixed by a mask as either software read/write (RW) or hardware-driven read-only (RO). Wide registers are accessed atomically: lower-word writes are staged and committed together on the top-word write, and a word-0 read snapshots the whole entry. The block is a drop-in register block for regular arrays of wide registers and sits directly on an rggen_axi4lite_if slave.

Parameters:
ADDRESS_WIDTH, 8, byte address width.
BUS_WIDTH, 32, AXI data width; 32 or 64.
DATA_WIDTH, 64, register width; a multiple of BUS_WIDTH. WORDS = DATA_WIDTH/BUS_WIDTH.
ENTRIES, 8, number of registers; 1 to 64.
BASE_ADDRESS, 0, byte offset of entry 0; aligned to DATA_WIDTH/8.
RW_MASK, all-ones, per bit: 1 = RW, 0 = RO.
INITIAL_VALUE, 0, reset value of the RW bits.
WRITE_FIRST, 1, priority when a read and a write are pending in the same cycle.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
axi4lite_if  rggen_axi4lite_if.slave  -  bus port; addr ADDRESS_WIDTH, data BUS_WIDTH
i_value  input  ENTRIES x DATA_WIDTH  RO bit sources; read where RW_MASK=0
o_value  output  ENTRIES x DATA_WIDTH  register contents; RW bits from storage, RO bits = i_value
o_write_trigger  output  ENTRIES  one-cycle pulse per committed entry

Behaviour:
- Reset: i_clk is the only clock; i_rst_n is asynchronous, active-low.
  - All ready/valid outputs are 0, bresp/rresp = 0, rdata = 0, o_write_trigger = 0.
  - RW storage = INITIAL_VALUE. Staging and snapshot buffers are cleared with their valid flags at 0.
  - Reset mid-transaction abandons it; no response is issued.
- Decode:
  - word = (addr - BASE_ADDRESS) >> log2(BUS_WIDTH/8); entry = word / WORDS; beat = word % WORDS.
  - Low address bits below bus alignment are ignored.
  - addr < BASE_ADDRESS or entry >= ENTRIES is out of range: SLVERR (2'b10), no side effects, rdata = 0.
- FSM states: IDLE, WRITE, READ, WAIT_B, WAIT_R. One transaction is outstanding at a time.
  - IDLE -> WRITE when awvalid && wvalid. IDLE -> READ when arvalid.
  - If both are pending: write wins when WRITE_FIRST=1, read wins otherwise.
  - A lone awvalid or a lone wvalid is not accepted; the block waits for both.
  - WRITE: awready and wready = 1 for exactly one cycle, then -> WAIT_B with bvalid=1 the next cycle (response 2 cycles after accept).
  - WAIT_B holds bvalid until bready, then -> IDLE.
  - READ: arready = 1 for one cycle, then -> WAIT_R with rvalid and rdata registered.
  - WAIT_R holds rvalid and rdata stable until rready, then -> IDLE.
  - The ready signals are never asserted outside WRITE/READ.
- Write, beat < WORDS-1:
  - Stage the strobed bytes into the staging buffer at that beat; OR wstrb into the staged strobe.
  - Set staging tag = entry. If the tag differed from the previous one, clear the staged strobe first.
  - Storage is unchanged. Response OKAY.
- Write, beat = WORDS-1 (commit):
  - Merge the staged bytes (only if tag == entry) with the current strobed bytes into storage.
  - Only RW_MASK bits change.
  - Clear the staging valid flag.
  - Pulse o_write_trigger[entry] the cycle after the WRITE state.
  - If WORDS == 1, every write commits and no staging logic exists.
- Read, beat 0:
  - Return the live value; capture the full o_value[entry] into the snapshot; set snapshot tag = entry.
- Read, beat > 0:
  - Return the snapshot word if the snapshot is valid and tag == entry; otherwise return the live word.
  - A commit to the snapshot entry invalidates the snapshot.
- rresp and bresp are OKAY in range and SLVERR out of range.
- A write with wstrb = 0 produces no byte changes. A commit with wstrb = 0 still pulses the trigger.

Test Plan:
- Reset, then read entry 3 (addr 0x18/0x1C; BUS 32, DATA 64, BASE 0, RW_MASK 64'h00FF00FF00FF00FF, i_value all 0xA5) -> rdata 0xA500A500 on both words, OKAY.
- Atomic write: write 0x11223344 to 0x08 -> o_value[1] unchanged, no trigger. Then write 0x55667788 to 0x0C -> o_value[1] = 64'hA566A588A522A544, o_write_trigger[1] pulses once.
- Staging retarget: write word0 of entry 2, then word0 of entry 4, then word1 of entry 4 -> entry 2 unchanged; only entry 4 is updated.
- Tear-free read: read 0x10, change i_value[2] to 0x5A, read 0x14 -> upper word still shows 0xA5 in the RO bytes.
- Arbitration: assert arvalid, awvalid and wvalid in the same cycle with WRITE_FIRST=1 -> awready precedes arready. With WRITE_FIRST=0 the order is reversed.
- Out of range: read 0x40 -> SLVERR with rdata 0. Write 0x44 -> SLVERR, no storage change, no trigger. Backpressure: rready low for 5 cycles -> rvalid and rdata stable.

Source files
------------

// File: rtl/rggen_axi4lite_wide_register_array.sv
// AXI4-Lite register array of ENTRIES wide registers with per-bit RW/RO masking.
// Writes to lower bus words are staged and land atomically with the top word;
// a word-0 read snapshots the entry so later words read tear-free.
// Bus ports carry the rggen_axi4lite_if slave signals as discrete wires.
`timescale 1ns / 1ps
module rggen_axi4lite_wide_register_array #(
    parameter int                    ADDRESS_WIDTH = 8,
    parameter int                    BUS_WIDTH     = 32,
    parameter int                    DATA_WIDTH    = 64,
    parameter int                    ENTRIES       = 8,
    parameter int unsigned           BASE_ADDRESS  = 0,
    parameter logic [DATA_WIDTH-1:0] RW_MASK       = '1,
    parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0,
    parameter bit                    WRITE_FIRST   = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [ADDRESS_WIDTH-1:0]      awaddr_i,
    input  logic                          awvalid_i,
    output logic                          awready_o,
    input  logic [BUS_WIDTH-1:0]          wdata_i,
    input  logic [BUS_WIDTH/8-1:0]        wstrb_i,
    input  logic                          wvalid_i,
    output logic                          wready_o,
    output logic                          bvalid_o,
    input  logic                          bready_i,
    output logic [1:0]                    bresp_o,
    input  logic [ADDRESS_WIDTH-1:0]      araddr_i,
    input  logic                          arvalid_i,
    output logic                          arready_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic [BUS_WIDTH-1:0]          rdata_o,
    output logic [1:0]                    rresp_o,
    input  logic [ENTRIES*DATA_WIDTH-1:0] i_value,
    output logic [ENTRIES*DATA_WIDTH-1:0] o_value,
    output logic [ENTRIES-1:0]            o_write_trigger
);

    localparam int         WORDS       = DATA_WIDTH / BUS_WIDTH;
    localparam int         BYTES       = BUS_WIDTH / 8;
    localparam int         ENTRY_BYTES = DATA_WIDTH / 8;
    localparam int         LSB         = $clog2(BYTES);
    localparam int         ENTRY_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int         BEAT_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [1:0] OKAY        = 2'b00;
    localparam logic [1:0] SLVERR      = 2'b10;

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_B, WAIT_R} state_e;

    typedef struct packed {
        logic               hit;
        logic [ENTRY_W-1:0] entry;
        logic [BEAT_W-1:0]  beat;
    } decode_t;

    // Byte address -> (in range, entry, beat); sub-word address bits drop out in the shift.
    function automatic decode_t decode(input logic [ADDRESS_WIDTH-1:0] addr);
        int unsigned a;
        int unsigned word;
        int unsigned ent;
        decode_t     d;
        a       = 32'(addr);
        word    = (a - BASE_ADDRESS) >> LSB;
        ent     = word / WORDS;
        d.hit   = (a >= BASE_ADDRESS) && (ent < ENTRIES);
        d.entry = ENTRY_W'(ent);
        d.beat  = BEAT_W'(word % WORDS);
        return d;
    endfunction

    state_e                  state_q;
    logic                    awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
    logic [1:0]              bresp_q, rresp_q;
    logic [BUS_WIDTH-1:0]    rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   storage_q [ENTRIES];
    logic [DATA_WIDTH-1:0]   value_w   [ENTRIES];
    logic [DATA_WIDTH-1:0]   stage_data_q, snap_data_q;
    logic [ENTRY_BYTES-1:0]  stage_strb_q;
    logic [ENTRY_W-1:0]      stage_tag_q, snap_tag_q;
    logic                    stage_valid_q, snap_valid_q;
    logic [ENTRIES-1:0]      trigger_q;
    decode_t                 wdec, rdec;
    logic                    do_write, do_commit, do_stage, do_read, stage_match;
    logic [DATA_WIDTH-1:0]   merged_data, merged_bits;
    logic [ENTRY_BYTES-1:0]  merged_strb;

    assign wdec        = decode(awaddr_i);
    assign rdec        = decode(araddr_i);
    assign do_write    = (state_q == WRITE) && wdec.hit;
    assign do_commit   = do_write && (wdec.beat == BEAT_W'(WORDS - 1));
    assign do_stage    = do_write && !do_commit;
    assign do_read     = (state_q == READ) && rdec.hit;
    // A staged word only counts toward the entry it was staged for. With WORDS == 1
    // every write commits, so the staging flops never load and fold away.
    assign stage_match = stage_valid_q && (stage_tag_q == wdec.entry);

    // Live register view: RW bits from storage, RO bits straight from hardware.
    for (genvar e = 0; e < ENTRIES; e++) begin : g_value
        assign value_w[e] = (storage_q[e] & RW_MASK) |
                            (i_value[e*DATA_WIDTH +: DATA_WIDTH] & ~RW_MASK);
        assign o_value[e*DATA_WIDTH +: DATA_WIDTH] = value_w[e];
    end

    // Overlay the strobed bytes of the current beat onto the (matching) staged entry.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        merged_data = stage_match ? stage_data_q : '0;
        merged_strb = stage_match ? stage_strb_q : '0;
        for (int b = 0; b < BYTES; b++) begin
            if (wstrb_i[b]) begin
                merged_data[int'(wdec.beat)*BUS_WIDTH + 8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
        merged_strb[int'(wdec.beat)*BYTES +: BYTES] |= wstrb_i;
        for (int b = 0; b < ENTRY_BYTES; b++) begin
            merged_bits[8*b +: 8] = {8{merged_strb[b]}};
        end
        merged_bits &= RW_MASK;
    end

    // Read word: snapshot for upper beats of the snapshotted entry, live otherwise.
    always_comb begin
        rdata_d = '0;
        if (rdec.hit) begin
            if ((rdec.beat != '0) && snap_valid_q && (snap_tag_q == rdec.entry)) begin
                rdata_d = snap_data_q[int'(rdec.beat)*BUS_WIDTH +: BUS_WIDTH];
            end else begin
                rdata_d = value_w[rdec.entry][int'(rdec.beat)*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // Bus FSM with registered handshake and response outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (awvalid_i && wvalid_i && (WRITE_FIRST || !arvalid_i)) begin
                        state_q   <= WRITE;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end else if (arvalid_i) begin
                        state_q   <= READ;
                        arready_q <= 1'b1;
                    end
                end
                WRITE: begin
                    state_q   <= WAIT_B;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= wdec.hit ? OKAY : SLVERR;
                end
                WAIT_B: begin
                    if (bready_i) begin
                        state_q  <= IDLE;
                        bvalid_q <= 1'b0;
                    end
                end
                READ: begin
                    state_q   <= WAIT_R;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    rdata_q   <= rdata_d;
                    rresp_q   <= rdec.hit ? OKAY : SLVERR;
                end
                WAIT_R: begin
                    if (rready_i) begin
                        state_q  <= IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Register storage: only RW bits of the committed entry change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the array is small and software expects defined reset values, so it is reset.
            for (int e = 0; e < ENTRIES; e++) begin
                storage_q[e] <= INITIAL_VALUE;
            end
        end else if (do_commit) begin
            storage_q[wdec.entry] <= (storage_q[wdec.entry] & ~merged_bits) |
                                     (merged_data & merged_bits);
        end
    end

    // Staging and snapshot buffers that make wide accesses atomic.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_data_q  <= '0;
            stage_strb_q  <= '0;
            stage_tag_q   <= '0;
            stage_valid_q <= 1'b0;
            snap_data_q   <= '0;
            snap_tag_q    <= '0;
            snap_valid_q  <= 1'b0;
        end else begin
            if (do_stage) begin
                stage_data_q  <= merged_data;
                stage_strb_q  <= merged_strb;
                stage_tag_q   <= wdec.entry;
                stage_valid_q <= 1'b1;
            end else if (do_commit) begin
                stage_valid_q <= 1'b0;
            end
            if (do_read && (rdec.beat == '0)) begin
                snap_data_q  <= value_w[rdec.entry];
                snap_tag_q   <= rdec.entry;
                snap_valid_q <= 1'b1;
            end else if (do_commit && (snap_tag_q == wdec.entry)) begin
                snap_valid_q <= 1'b0;
            end
        end
    end

    // One-cycle trigger for the entry committed in the WRITE state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            trigger_q <= '0;
        end else begin
            trigger_q <= do_commit ? (ENTRIES'(1) << wdec.entry) : '0;
        end
    end

    assign awready_o       = awready_q;
    assign wready_o        = wready_q;
    assign arready_o       = arready_q;
    assign bvalid_o        = bvalid_q;
    assign bresp_o         = bresp_q;
    assign rvalid_o        = rvalid_q;
    assign rresp_o         = rresp_q;
    assign rdata_o         = rdata_q;
    assign o_write_trigger = trigger_q;

endmodule

// File: tb/tb_rggen_axi4lite_wide_register_array.sv
// Scoreboard bench: drivers queue expected bus responses, a negedge monitor
// pops and compares them when the DUT completes a B or R handshake.
`timescale 1ns / 1ps
module tb_rggen_axi4lite_wide_register_array;

    localparam logic [63:0] MASK   = 64'h00FF_00FF_00FF_00FF;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   awaddr, araddr;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         awvalid, wvalid, arvalid, bready, rready;
    logic         awready, wready, arready, bvalid, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [511:0] i_value, o_value;
    logic [7:0]   trig;
    // second instance, read-first arbitration
    logic         b_awvalid, b_wvalid, b_arvalid;
    logic         b_awready, b_wready, b_arready, b_bvalid, b_rvalid;
    logic [1:0]   b_bresp, b_rresp;
    logic [31:0]  b_rdata;
    logic [511:0] b_o_value;
    logic [7:0]   b_trig;
    logic         b_ready = 1'b1;

    always #5 clk = ~clk;

    rggen_axi4lite_wide_register_array #(
        .RW_MASK(MASK), .INITIAL_VALUE(64'h0), .WRITE_FIRST(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
        .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
        .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
        .i_value(i_value), .o_value(o_value), .o_write_trigger(trig)
    );

    rggen_axi4lite_wide_register_array #(
        .RW_MASK(MASK), .INITIAL_VALUE(64'h0), .WRITE_FIRST(1'b0)
    ) dut_rf (
        .i_clk(clk), .i_rst_n(rst_n),
        .awaddr_i(awaddr), .awvalid_i(b_awvalid), .awready_o(b_awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(b_wvalid), .wready_o(b_wready),
        .bvalid_o(b_bvalid), .bready_i(b_ready), .bresp_o(b_bresp),
        .araddr_i(araddr), .arvalid_i(b_arvalid), .arready_o(b_arready),
        .rvalid_o(b_rvalid), .rready_i(b_ready), .rdata_o(b_rdata), .rresp_o(b_rresp),
        .i_value(i_value), .o_value(b_o_value), .o_write_trigger(b_trig)
    );

    typedef struct {
        bit          is_read;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [7:0]  trig;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   trig_follow = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake, required one within the cycle bound", name);
    endtask

    task automatic expect_item(input bit rd, input logic [1:0] resp, input logic [31:0] data,
                               input logic [7:0] tr, input string name);
        exp_t e;
        e.is_read = rd;
        e.resp    = resp;
        e.data    = data;
        e.trig    = tr;
        e.name    = name;
        sb.push_back(e);
    endtask

    // Monitor: compare each completed response against the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (trig_follow) begin
            trig_follow = 1'b0;
            check("trigger_one_shot", 64'(trig), 64'h0);
        end
        if (bvalid && bready) begin
            if (sb.size() == 0) begin
                fail_timeout("unexpected_b_response");
            end else begin
                e = sb.pop_front();
                check({e.name, "_kind"}, 64'(e.is_read), 64'h0);
                check({e.name, "_bresp"}, 64'(bresp), 64'(e.resp));
                check({e.name, "_trigger"}, 64'(trig), 64'(e.trig));
                trig_follow = 1'b1;
            end
        end
        if (rvalid && rready) begin
            if (sb.size() == 0) begin
                fail_timeout("unexpected_r_response");
            end else begin
                e = sb.pop_front();
                check({e.name, "_kind"}, 64'(e.is_read), 64'h1);
                check({e.name, "_rresp"}, 64'(rresp), 64'(e.resp));
                check({e.name, "_rdata"}, 64'(rdata), 64'(e.data));
            end
        end
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp, input logic [7:0] tr, input string name);
        int n;
        expect_item(1'b0, resp, 32'h0, tr, name);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        if (!awready) begin
            fail_timeout({name, "_awready"});
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 50);
        if (!bvalid) fail_timeout({name, "_bvalid"});
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [1:0] resp, input logic [31:0] d,
                            input string name);
        int n;
        expect_item(1'b1, resp, d, 8'h0, name);
        araddr = a; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) begin
            fail_timeout({name, "_arready"});
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 50);
        if (!rvalid) fail_timeout({name, "_rvalid"});
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200us");
        $fatal(1);
    end

    initial begin : stimulus
        int  n;
        int  aw0, ar0, aw1, ar1;
        bit  a0, r0, a1, r1;
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        b_awvalid = 1'b0; b_wvalid = 1'b0; b_arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        i_value = {64{8'hA5}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_handshake", 64'({awready, wready, arready, bvalid, rvalid}), 64'h0);
        check("reset_resp", 64'({bresp, rresp}), 64'h0);
        check("reset_rdata", 64'(rdata), 64'h0);
        check("reset_trigger", 64'(trig), 64'h0);
        check("reset_value0", o_value[0 +: 64], 64'hA500_A500_A500_A500);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // entry 3 after reset: RW bytes zero, RO bytes from i_value
        axi_read(8'h18, OKAY, 32'hA500_A500, "rd_e3_w0");
        axi_read(8'h1C, OKAY, 32'hA500_A500, "rd_e3_w1");

        // atomic write of entry 1
        axi_write(8'h08, 32'h1122_3344, 4'hF, OKAY, 8'h00, "wr_e1_w0");
        check("e1_after_stage", o_value[64 +: 64], 64'hA500_A500_A500_A500);
        axi_write(8'h0C, 32'h5566_7788, 4'hF, OKAY, 8'h02, "wr_e1_w1");
        check("e1_after_commit", o_value[64 +: 64], 64'hA566_A588_A522_A544);
        axi_read(8'h08, OKAY, 32'hA522_A544, "rd_e1_w0");
        axi_read(8'h0C, OKAY, 32'hA566_A588, "rd_e1_w1");

        // staging retargeted from entry 2 to entry 4
        axi_write(8'h10, 32'h0102_0304, 4'hF, OKAY, 8'h00, "wr_e2_w0");
        axi_write(8'h20, 32'hDEAD_BEEF, 4'hF, OKAY, 8'h00, "wr_e4_w0");
        axi_write(8'h24, 32'hCAFE_F00D, 4'hF, OKAY, 8'h10, "wr_e4_w1");
        check("e2_untouched", o_value[128 +: 64], 64'hA500_A500_A500_A500);
        check("e4_committed", o_value[256 +: 64], 64'hA5FE_A50D_A5AD_A5EF);

        // tear-free read across an i_value change
        axi_read(8'h10, OKAY, 32'hA500_A500, "tear_w0");
        i_value[128 +: 64] = {8{8'h5A}};
        axi_read(8'h14, OKAY, 32'hA500_A500, "tear_w1_snap");
        axi_read(8'h10, OKAY, 32'h5A00_5A00, "tear_w0_live");
        axi_read(8'h14, OKAY, 32'h5A00_5A00, "tear_w1_new");

        // a commit to the snapshot entry invalidates the snapshot
        axi_read(8'h18, OKAY, 32'hA500_A500, "inv_w0");
        axi_write(8'h1C, 32'h1234_5678, 4'hF, OKAY, 8'h08, "inv_wr");
        axi_read(8'h1C, OKAY, 32'hA534_A578, "inv_w1_live");

        // empty strobes and a staged single byte
        axi_write(8'h0C, 32'hFFFF_FFFF, 4'h0, OKAY, 8'h02, "strb0_commit");
        check("e1_strb0", o_value[64 +: 64], 64'hA566_A588_A522_A544);
        axi_write(8'h08, 32'hAABB_CCDD, 4'h1, OKAY, 8'h00, "byte_stage");
        axi_write(8'h0C, 32'h0000_0000, 4'h0, OKAY, 8'h02, "byte_commit");
        check("e1_byte_merge", o_value[64 +: 64], 64'hA566_A588_A522_A5DD);

        // range boundary
        axi_read(8'h3C, OKAY, 32'hA500_A500, "rd_last_entry");
        axi_read(8'h40, SLVERR, 32'h0, "rd_oor");
        axi_write(8'h44, 32'hFFFF_FFFF, 4'hF, SLVERR, 8'h00, "wr_oor");
        check("oor_e0", o_value[0 +: 64], 64'hA500_A500_A500_A500);
        check("oor_e1", o_value[64 +: 64], 64'hA566_A588_A522_A5DD);

        // read backpressure
        rready = 1'b0;
        expect_item(1'b1, OKAY, 32'hA522_A5DD, 8'h0, "backpressure");
        araddr = 8'h08; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) fail_timeout("bp_arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 50);
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid", 64'(rvalid), 64'h1);
            check("bp_rdata", 64'(rdata), 64'hA522_A5DD);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        @(posedge clk); #1;

        // simultaneous read and write on both arbitration variants
        expect_item(1'b0, SLVERR, 32'h0, 8'h00, "arb_wr");
        expect_item(1'b1, SLVERR, 32'h0, 8'h00, "arb_rd");
        awaddr = 8'h44; wdata = 32'h0; wstrb = 4'hF; araddr = 8'h40;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        b_awvalid = 1'b1; b_wvalid = 1'b1; b_arvalid = 1'b1;
        aw0 = -1; ar0 = -1; aw1 = -1; ar1 = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            a0 = awready; r0 = arready; a1 = b_awready; r1 = b_arready;
            if (a0) aw0 = k;
            if (r0) ar0 = k;
            if (a1) aw1 = k;
            if (r1) ar1 = k;
            @(posedge clk); #1;
            if (a0) begin awvalid = 1'b0; wvalid = 1'b0; end
            if (r0) arvalid = 1'b0;
            if (a1) begin b_awvalid = 1'b0; b_wvalid = 1'b0; end
            if (r1) b_arvalid = 1'b0;
            if (aw0 >= 0 && ar0 >= 0 && aw1 >= 0 && ar1 >= 0) break;
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        b_awvalid = 1'b0; b_wvalid = 1'b0; b_arvalid = 1'b0;
        if (aw0 < 0 || ar0 < 0 || aw1 < 0 || ar1 < 0) begin
            fail_timeout("arbitration");
        end else begin
            check("arb_write_first", 64'(aw0 < ar0), 64'h1);
            check("arb_read_first", 64'(ar1 < aw1), 64'h1);
        end
        repeat (8) @(posedge clk);

        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
